// File: rtl/gpio_cfg_pkg.sv
// rtl/gpio_cfg_pkg.sv - shared constants, FSM states and config-word field map for the GPIO control chains
//
// Purpose : common definitions used by the serial loader, housekeeping and the
//           GPIO control blocks.
// Ports   : none (package).

package gpio_cfg_pkg;

  // Chain geometry
  localparam int GPIO_CFG_BITS   = 13;
  localparam int GPIO_NUM_CHAIN1 = 19;  // GPIO 0..18
  localparam int GPIO_NUM_CHAIN2 = 19;  // GPIO 19..37
  localparam int GPIO_NUM_TOTAL  = GPIO_NUM_CHAIN1 + GPIO_NUM_CHAIN2;

  // Serial loader FSM
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    LOAD     = 3'd3,
    FINISH   = 3'd4
  } ser_state_e;

  // Bit offsets inside one 13-bit control-block configuration word
  localparam int CFG_MGMT_EN     = 0;   // management controls the pad
  localparam int CFG_OUT_DIS     = 1;   // output driver disable
  localparam int CFG_HOLD_OVR    = 2;   // hold override
  localparam int CFG_INP_DIS     = 3;   // input buffer disable
  localparam int CFG_IB_MODE_SEL = 4;   // input buffer mode select
  localparam int CFG_ANA_EN      = 5;   // analog bus enable
  localparam int CFG_ANA_SEL     = 6;   // analog bus select
  localparam int CFG_ANA_POL     = 7;   // analog bus polarity
  localparam int CFG_SLOW_SLEW   = 8;   // slow slew rate
  localparam int CFG_TRIP_SEL    = 9;   // input trip point select
  localparam int CFG_DM_LSB      = 10;  // drive mode, 3 bits
  localparam int CFG_DM_WIDTH    = 3;

endpackage

// File: rtl/gpio_serial_divider.sv
// rtl/gpio_serial_divider.sv - half-period counter producing serial phase-advance strobes
//
// Purpose : while i_run is high, pulse o_tick on the last system clock of
//           every CLK_DIV-cycle phase. The count restarts from zero whenever
//           i_run is low, so the first phase after a start is a full one.
// Ports   : i_clock  system clock
//           i_reset  asynchronous active-high reset
//           i_run    phase counting enable
//           o_tick   strobe on the last cycle of each phase

module gpio_serial_divider #(
  parameter int CLK_DIV = 2
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_run,
  output logic o_tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_tick;

  assign w_tick = i_run && (r_cnt == CNT_LAST);
  assign o_tick = w_tick;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (!i_run || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/gpio_serial_loader.sv
// rtl/gpio_serial_loader.sv - serial configuration engine for the two GPIO control-block chains
//
// Purpose : on xfer_start shifts every configuration word into both chains
//           (chain 1 GPIO 18..0, chain 2 GPIO 19..37, MSB first) and then
//           pulses serial_load. In bit-bang mode the bb_* levels are passed
//           through to the chains with one cycle of latency.
// Ports   : clock, reset                 system clock, async active-high reset
//           xfer_start                   single-cycle transfer request
//           gpio_config                  flat words, word g at [g*CFG_BITS +: CFG_BITS]
//           bb_enable                    bit-bang mode select
//           bb_resetn/load/clock         bit-bang control levels
//           bb_data_1, bb_data_2         bit-bang data per chain
//           serial_clock/load/resetn     shared chain controls (registered)
//           serial_data_1, serial_data_2 chain data (registered)
//           busy, done                   transfer in progress, end-of-transfer pulse

module gpio_serial_loader
  import gpio_cfg_pkg::*;
#(
  parameter int NUM_GPIO_1 = GPIO_NUM_CHAIN1,
  parameter int NUM_GPIO_2 = GPIO_NUM_CHAIN2,  // must equal NUM_GPIO_1
  parameter int CFG_BITS   = GPIO_CFG_BITS,
  parameter int CLK_DIV    = 2
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic                                       xfer_start,
  input  logic [(NUM_GPIO_1+NUM_GPIO_2)*CFG_BITS-1:0] gpio_config,
  input  logic                                       bb_enable,
  input  logic                                       bb_resetn,
  input  logic                                       bb_load,
  input  logic                                       bb_clock,
  input  logic                                       bb_data_1,
  input  logic                                       bb_data_2,
  output logic                                       serial_clock,
  output logic                                       serial_load,
  output logic                                       serial_resetn,
  output logic                                       serial_data_1,
  output logic                                       serial_data_2,
  output logic                                       busy,
  output logic                                       done
);

  localparam int NUM_GPIO = NUM_GPIO_1 + NUM_GPIO_2;
  localparam int IDX_W    = $clog2(NUM_GPIO);
  localparam int WORD_W   = (NUM_GPIO_1 > 1) ? $clog2(NUM_GPIO_1) : 1;
  localparam int BIT_W    = $clog2(CFG_BITS);

  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(NUM_GPIO_1 - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(CFG_BITS - 1);

  ser_state_e          r_state;
  logic [BIT_W-1:0]    r_bit_cnt;
  logic [WORD_W-1:0]   r_word_cnt;
  // Staging registers hold the bits of the current word not yet presented.
  logic [CFG_BITS-1:0] r_shift_1;
  logic [CFG_BITS-1:0] r_shift_2;

  logic                w_run;
  logic                w_tick;
  logic [WORD_W-1:0]   w_word_sel;
  logic [IDX_W-1:0]    w_idx_1;
  logic [IDX_W-1:0]    w_idx_2;
  logic [CFG_BITS-1:0] w_words [NUM_GPIO];
  logic [CFG_BITS-1:0] w_cfg_1;
  logic [CFG_BITS-1:0] w_cfg_2;

  assign w_run = (r_state != IDLE);

  gpio_serial_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_divider (
    .i_clock (clock),
    .i_reset (reset),
    .i_run   (w_run),
    .o_tick  (w_tick)
  );

  for (genvar g = 0; g < NUM_GPIO; g++) begin : g_words
    assign w_words[g] = gpio_config[g*CFG_BITS +: CFG_BITS];
  end

  // Index of the word to capture next: word 0 when starting a transfer,
  // otherwise the one after the current word.
  assign w_word_sel = (r_state == IDLE || r_word_cnt == LAST_WORD) ? '0 : r_word_cnt + 1'b1;

  // First-shifted data travels furthest: chain 1 counts down from GPIO 18,
  // chain 2 counts up from GPIO 19.
  assign w_idx_1 = IDX_W'(NUM_GPIO_1 - 1) - IDX_W'(w_word_sel);
  assign w_idx_2 = IDX_W'(NUM_GPIO_1) + IDX_W'(w_word_sel);
  assign w_cfg_1 = w_words[w_idx_1];
  assign w_cfg_2 = w_words[w_idx_2];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_bit_cnt     <= '0;
      r_word_cnt    <= '0;
      r_shift_1     <= '0;
      r_shift_2     <= '0;
      serial_clock  <= 1'b0;
      serial_load   <= 1'b0;
      serial_resetn <= 1'b0;
      serial_data_1 <= 1'b0;
      serial_data_2 <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          busy <= 1'b0;
          if (bb_enable) begin
            serial_clock  <= bb_clock;
            serial_load   <= bb_load;
            serial_resetn <= bb_resetn;
            serial_data_1 <= bb_data_1;
            serial_data_2 <= bb_data_2;
          end else begin
            serial_clock  <= 1'b0;
            serial_load   <= 1'b0;
            serial_resetn <= 1'b1;
            serial_data_1 <= 1'b0;
            serial_data_2 <= 1'b0;
            // busy is still high during the done cycle, which is spent in
            // IDLE; a request is only taken once busy has fallen.
            if (xfer_start && !busy) begin
              r_state       <= SHIFT_LO;
              busy          <= 1'b1;
              r_bit_cnt     <= '0;
              r_word_cnt    <= '0;
              r_shift_1     <= {w_cfg_1[CFG_BITS-2:0], 1'b0};
              r_shift_2     <= {w_cfg_2[CFG_BITS-2:0], 1'b0};
              serial_data_1 <= w_cfg_1[CFG_BITS-1];
              serial_data_2 <= w_cfg_2[CFG_BITS-1];
            end
          end
        end

        SHIFT_LO: begin
          if (w_tick) begin
            r_state      <= SHIFT_HI;
            serial_clock <= 1'b1;
          end
        end

        SHIFT_HI: begin
          if (w_tick) begin
            serial_clock <= 1'b0;
            if (r_bit_cnt == LAST_BIT) begin
              r_bit_cnt <= '0;
              if (r_word_cnt == LAST_WORD) begin
                r_word_cnt    <= '0;
                r_state       <= LOAD;
                serial_load   <= 1'b1;
                serial_data_1 <= 1'b0;
                serial_data_2 <= 1'b0;
              end else begin
                r_word_cnt    <= r_word_cnt + 1'b1;
                r_state       <= SHIFT_LO;
                r_shift_1     <= {w_cfg_1[CFG_BITS-2:0], 1'b0};
                r_shift_2     <= {w_cfg_2[CFG_BITS-2:0], 1'b0};
                serial_data_1 <= w_cfg_1[CFG_BITS-1];
                serial_data_2 <= w_cfg_2[CFG_BITS-1];
              end
            end else begin
              r_bit_cnt     <= r_bit_cnt + 1'b1;
              r_state       <= SHIFT_LO;
              r_shift_1     <= {r_shift_1[CFG_BITS-2:0], 1'b0};
              r_shift_2     <= {r_shift_2[CFG_BITS-2:0], 1'b0};
              serial_data_1 <= r_shift_1[CFG_BITS-1];
              serial_data_2 <= r_shift_2[CFG_BITS-1];
            end
          end
        end

        LOAD: begin
          if (w_tick) begin
            r_state     <= FINISH;
            serial_load <= 1'b0;
          end
        end

        FINISH: begin
          // busy stays high through the done cycle.
          if (w_tick) begin
            r_state <= IDLE;
            done    <= 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_serial_loader.sv
// tb/tb_gpio_serial_loader.sv - self-checking bench for gpio_serial_loader

module tb_gpio_serial_loader;

  localparam int NB    = 13;
  localparam int NC    = 19;
  localparam int NG    = 2 * NC;
  localparam int NBITS = NC * NB;
  localparam int HA    = 2;
  localparam int HB    = 1;
  localparam int END_A = 1 + 2 * NBITS * HA + 2 * HA;
  localparam int END_B = 1 + 2 * NBITS * HB + 2 * HB;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic xfer_start = 1'b0;
  logic bb_enable = 1'b0;
  logic bb_resetn = 1'b0;
  logic bb_load = 1'b0;
  logic bb_clock = 1'b0;
  logic bb_data_1 = 1'b0;
  logic bb_data_2 = 1'b0;
  logic [NG*NB-1:0] gpio_config;
  logic [NB-1:0] cfg [NG];

  logic a_sclk, a_sload, a_srstn, a_sd1, a_sd2, a_busy, a_done;
  logic b_sclk, b_sload, b_srstn, b_sd1, b_sd2, b_busy, b_done;

  int n_checks = 0;
  int n_fail = 0;

  bit a_s1[$], a_s2[$], b_s1[$], b_s2[$];
  int a_load_first, a_load_last, a_done_cyc, a_done_cnt, a_rise_bad, a_busy_bad, a_rst_bad;
  int b_load_first, b_load_last, b_done_cyc, b_done_cnt, b_rise_bad, b_busy_bad, b_rst_bad;

  always #5 clock = ~clock;

  always_comb begin
    gpio_config = '0;
    for (int g = 0; g < NG; g++) gpio_config[g*NB +: NB] = cfg[g];
  end

  gpio_serial_loader #(.CLK_DIV(HA)) u_dut_a (
    .clock(clock), .reset(reset), .xfer_start(xfer_start), .gpio_config(gpio_config),
    .bb_enable(bb_enable), .bb_resetn(bb_resetn), .bb_load(bb_load), .bb_clock(bb_clock),
    .bb_data_1(bb_data_1), .bb_data_2(bb_data_2),
    .serial_clock(a_sclk), .serial_load(a_sload), .serial_resetn(a_srstn),
    .serial_data_1(a_sd1), .serial_data_2(a_sd2), .busy(a_busy), .done(a_done)
  );

  gpio_serial_loader #(.CLK_DIV(HB)) u_dut_b (
    .clock(clock), .reset(reset), .xfer_start(xfer_start), .gpio_config(gpio_config),
    .bb_enable(bb_enable), .bb_resetn(bb_resetn), .bb_load(bb_load), .bb_clock(bb_clock),
    .bb_data_1(bb_data_1), .bb_data_2(bb_data_2),
    .serial_clock(b_sclk), .serial_load(b_sload), .serial_resetn(b_srstn),
    .serial_data_1(b_sd1), .serial_data_2(b_sd2), .busy(b_busy), .done(b_done)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Chain model: the bit stream seen at serial_clock rises, cut into 13-bit
  // words in shift order; word j ends in block 18-j (chain 1) or 19+j (chain 2).
  function automatic logic [NB-1:0] chain_word(input bit s[$], input int g);
    logic [NB-1:0] w;
    int j;
    w = '0;
    j = (g < NC) ? (NC - 1 - g) : (g - NC);
    for (int b = 0; b < NB; b++)
      if (j * NB + b < s.size()) w[NB-1-b] = s[j*NB + b];
    return w;
  endfunction

  function automatic int decode_errs(input bit s1[$], input bit s2[$]);
    int e;
    e = 0;
    for (int g = 0; g < NG; g++) begin
      if (g < NC) begin
        if (chain_word(s1, g) !== cfg[g]) e++;
      end else begin
        if (chain_word(s2, g) !== cfg[g]) e++;
      end
    end
    return e;
  endfunction

  // Starts a transfer and records what both chains see for 1100 cycles.
  // At cycle 'inject' a second request and bit-bang mode are raised.
  task automatic run_xfer(input int inject);
    a_s1.delete(); a_s2.delete(); b_s1.delete(); b_s2.delete();
    a_load_first = -1; a_load_last = -1; a_done_cyc = -1; a_done_cnt = 0;
    a_rise_bad = 0; a_busy_bad = 0; a_rst_bad = 0;
    b_load_first = -1; b_load_last = -1; b_done_cyc = -1; b_done_cnt = 0;
    b_rise_bad = 0; b_busy_bad = 0; b_rst_bad = 0;
    xfer_start = 1'b1;
    tick();
    xfer_start = 1'b0;
    begin
      logic a_prev, b_prev;
      a_prev = 1'b0;
      b_prev = 1'b0;
      for (int c = 1; c <= 1100; c++) begin
        if (a_busy && a_sclk && !a_prev) begin
          if (c != 1 + 2 * a_s1.size() * HA + HA) a_rise_bad++;
          a_s1.push_back(a_sd1);
          a_s2.push_back(a_sd2);
        end
        if (a_busy !== (c <= END_A)) a_busy_bad++;
        if (a_busy && a_srstn !== 1'b1) a_rst_bad++;
        if (a_busy && a_sload) begin
          if (a_load_first < 0) a_load_first = c;
          a_load_last = c;
        end
        if (a_done) begin a_done_cnt++; a_done_cyc = c; end
        a_prev = a_sclk;

        if (b_busy && b_sclk && !b_prev) begin
          if (c != 1 + 2 * b_s1.size() * HB + HB) b_rise_bad++;
          b_s1.push_back(b_sd1);
          b_s2.push_back(b_sd2);
        end
        if (b_busy !== (c <= END_B)) b_busy_bad++;
        if (b_busy && b_srstn !== 1'b1) b_rst_bad++;
        if (b_busy && b_sload) begin
          if (b_load_first < 0) b_load_first = c;
          b_load_last = c;
        end
        if (b_done) begin b_done_cnt++; b_done_cyc = c; end
        b_prev = b_sclk;

        if (c == inject) begin
          xfer_start = 1'b1;
          bb_enable = 1'b1;
          bb_clock = 1'b1;
          bb_load = 1'b1;
          bb_resetn = 1'b0;
          bb_data_1 = 1'b1;
          bb_data_2 = 1'b1;
        end else if (c == inject + 1) begin
          xfer_start = 1'b0;
        end
        tick();
      end
    end
  endtask

  task automatic test_reset();
    int dn;
    reset = 1'b1;
    tick(); tick();
    n_checks++;
    if ({a_sclk, a_sload, a_srstn, a_sd1, a_sd2, a_busy, a_done} !== 7'b0) begin
      n_fail++; $display("FAIL reset_outputs_a: got %b expected 0000000", {a_sclk, a_sload, a_srstn, a_sd1, a_sd2, a_busy, a_done});
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if ({a_srstn, b_srstn} !== 2'b11) begin
      n_fail++; $display("FAIL resetn_release: got %b expected 11", {a_srstn, b_srstn});
    end
    for (int g = 0; g < NG; g++) cfg[g] = NB'($urandom);
    xfer_start = 1'b1;
    tick();
    xfer_start = 1'b0;
    repeat (20) tick();
    n_checks++;
    if (a_busy !== 1'b1) begin n_fail++; $display("FAIL busy_before_reset: got %b expected 1", a_busy); end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({a_srstn, a_busy, a_sclk, b_srstn, b_busy} !== 5'b0) begin
      n_fail++; $display("FAIL midshift_reset: got %b expected 00000", {a_srstn, a_busy, a_sclk, b_srstn, b_busy});
    end
    tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if (a_srstn !== 1'b1) begin n_fail++; $display("FAIL resetn_after_midshift: got %b expected 1", a_srstn); end
    dn = 0;
    for (int c = 0; c < 1100; c++) begin
      if (a_done || b_done || a_busy || b_busy) dn++;
      tick();
    end
    n_checks++;
    if (dn !== 0) begin n_fail++; $display("FAIL no_done_after_reset: got %0d active cycles expected 0", dn); end
  endtask

  task automatic test_full_transfer();
    for (int g = 0; g < NG; g++) cfg[g] = NB'(g + 1);
    run_xfer(0);
    n_checks++;
    if (a_s1.size() !== NBITS) begin n_fail++; $display("FAIL bit_count_a: got %0d expected %0d", a_s1.size(), NBITS); end
    n_checks++;
    if (chain_word(a_s1, 0) !== 13'h001) begin n_fail++; $display("FAIL gpio0_word: got %h expected 001", chain_word(a_s1, 0)); end
    n_checks++;
    if (chain_word(a_s2, 37) !== 13'h026) begin n_fail++; $display("FAIL gpio37_word: got %h expected 026", chain_word(a_s2, 37)); end
    n_checks++;
    if (decode_errs(a_s1, a_s2) !== 0) begin n_fail++; $display("FAIL chain_words_a: got %0d bad words expected 0", decode_errs(a_s1, a_s2)); end
    n_checks++;
    if (a_load_first !== 989 || a_load_last !== 990) begin
      n_fail++; $display("FAIL load_window_a: got %0d..%0d expected 989..990", a_load_first, a_load_last);
    end
    n_checks++;
    if (a_done_cyc !== 993 || a_done_cnt !== 1) begin
      n_fail++; $display("FAIL done_a: got cycle %0d count %0d expected cycle 993 count 1", a_done_cyc, a_done_cnt);
    end
    n_checks++;
    if (a_rise_bad + a_busy_bad + a_rst_bad !== 0) begin
      n_fail++; $display("FAIL timing_a: got rise %0d busy %0d resetn %0d errors expected 0", a_rise_bad, a_busy_bad, a_rst_bad);
    end
    n_checks++;
    if (b_done_cyc !== 497 || b_done_cnt !== 1) begin
      n_fail++; $display("FAIL done_b: got cycle %0d count %0d expected cycle 497 count 1", b_done_cyc, b_done_cnt);
    end
    n_checks++;
    if (b_load_first !== 1 + 2 * NBITS || b_load_last !== 1 + 2 * NBITS) begin
      n_fail++; $display("FAIL load_window_b: got %0d..%0d expected %0d", b_load_first, b_load_last, 1 + 2 * NBITS);
    end
    n_checks++;
    if (decode_errs(b_s1, b_s2) !== 0 || b_rise_bad + b_busy_bad + b_rst_bad !== 0) begin
      n_fail++; $display("FAIL transfer_b: got %0d bad words, %0d timing errors expected 0", decode_errs(b_s1, b_s2), b_rise_bad + b_busy_bad + b_rst_bad);
    end
  endtask

  task automatic test_pattern();
    for (int g = 0; g < NG; g++) cfg[g] = '0;
    cfg[0] = 13'h1803;
    cfg[37] = 13'h1803;
    run_xfer(0);
    n_checks++;
    if (chain_word(a_s1, 0) !== 13'h1803 || chain_word(a_s2, 37) !== 13'h1803) begin
      n_fail++; $display("FAIL pattern_ends: got %h %h expected 1803 1803", chain_word(a_s1, 0), chain_word(a_s2, 37));
    end
    n_checks++;
    if (decode_errs(a_s1, a_s2) !== 0 || decode_errs(b_s1, b_s2) !== 0) begin
      n_fail++; $display("FAIL pattern_others: got %0d/%0d bad words expected 0", decode_errs(a_s1, a_s2), decode_errs(b_s1, b_s2));
    end
  endtask

  task automatic test_random_config();
    for (int r = 0; r < 2; r++) begin
      for (int g = 0; g < NG; g++) cfg[g] = NB'($urandom);
      run_xfer(0);
      n_checks++;
      if (decode_errs(a_s1, a_s2) !== 0 || a_done_cyc !== END_A || a_rise_bad !== 0) begin
        n_fail++; $display("FAIL random_a: got %0d bad words, done %0d, rise errors %0d expected 0, %0d, 0", decode_errs(a_s1, a_s2), a_done_cyc, a_rise_bad, END_A);
      end
      n_checks++;
      if (decode_errs(b_s1, b_s2) !== 0 || b_done_cyc !== END_B || b_rise_bad !== 0) begin
        n_fail++; $display("FAIL random_b: got %0d bad words, done %0d, rise errors %0d expected 0, %0d, 0", decode_errs(b_s1, b_s2), b_done_cyc, b_rise_bad, END_B);
      end
    end
  endtask

  task automatic test_bitbang();
    logic [4:0] exp_lv;
    bb_enable = 1'b1;
    for (int i = 0; i < 24; i++) begin
      bb_clock = i[0];
      bb_load = 1'($urandom);
      bb_resetn = 1'($urandom);
      bb_data_1 = 1'($urandom);
      bb_data_2 = 1'($urandom);
      xfer_start = 1'($urandom);
      exp_lv = {bb_clock, bb_load, bb_resetn, bb_data_1, bb_data_2};
      tick();
      n_checks++;
      if ({a_sclk, a_sload, a_srstn, a_sd1, a_sd2} !== exp_lv || {b_sclk, b_sload, b_srstn, b_sd1, b_sd2} !== exp_lv || {a_busy, b_busy} !== 2'b00) begin
        n_fail++; $display("FAIL bitbang_mirror[%0d]: got %b/%b busy %b%b expected %b busy 00", i, {a_sclk, a_sload, a_srstn, a_sd1, a_sd2}, {b_sclk, b_sload, b_srstn, b_sd1, b_sd2}, a_busy, b_busy, exp_lv);
      end
    end
    xfer_start = 1'b0;
    bb_enable = 1'b0;
    tick(); tick();
  endtask

  task automatic test_collision();
    logic [4:0] exp_lv;
    for (int g = 0; g < NG; g++) cfg[g] = NB'($urandom);
    run_xfer(100);
    n_checks++;
    if (decode_errs(a_s1, a_s2) !== 0 || a_done_cyc !== END_A || a_done_cnt !== 1) begin
      n_fail++; $display("FAIL collision_a: got %0d bad words, done %0d x%0d expected 0, %0d x1", decode_errs(a_s1, a_s2), a_done_cyc, a_done_cnt, END_A);
    end
    n_checks++;
    if (a_rise_bad + a_busy_bad + a_rst_bad + b_rise_bad + b_busy_bad + b_rst_bad !== 0 || b_done_cyc !== END_B) begin
      n_fail++; $display("FAIL collision_timing: got %0d errors, done_b %0d expected 0, %0d", a_rise_bad + a_busy_bad + a_rst_bad + b_rise_bad + b_busy_bad + b_rst_bad, b_done_cyc, END_B);
    end
    for (int i = 0; i < 4; i++) begin
      bb_clock = 1'($urandom);
      bb_load = 1'($urandom);
      bb_resetn = 1'($urandom);
      bb_data_1 = 1'($urandom);
      bb_data_2 = 1'($urandom);
      exp_lv = {bb_clock, bb_load, bb_resetn, bb_data_1, bb_data_2};
      tick();
      n_checks++;
      if ({a_sclk, a_sload, a_srstn, a_sd1, a_sd2} !== exp_lv) begin
        n_fail++; $display("FAIL post_collision_bitbang[%0d]: got %b expected %b", i, {a_sclk, a_sload, a_srstn, a_sd1, a_sd2}, exp_lv);
      end
    end
    bb_enable = 1'b0;
    {bb_clock, bb_load, bb_resetn, bb_data_1, bb_data_2} = 5'b0;
    tick(); tick();
  endtask

  initial begin
    for (int g = 0; g < NG; g++) cfg[g] = '0;
    test_reset();
    test_full_transfer();
    test_pattern();
    test_random_config();
    test_bitbang();
    test_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_serial_loader.md
# gpio_serial_loader

Serial configuration engine that drives the two GPIO control-block shift chains of the management SoC: user chain 1 (GPIO 0–18) and user chain 2 (GPIO 19–37). It sits directly upstream of the GPIO control blocks, inside housekeeping beside the bit-bang control register.
- On a transfer request it shifts all 38 13-bit configuration words out automatically, then pulses load.
- When bit-bang mode is enabled it instead passes the register-driven bit-bang levels through to the chains.

## Interface
Parameters:
- NUM_GPIO_1, 19, number of control blocks on chain 1 (GPIO 0..18)
- NUM_GPIO_2, 19, number of control blocks on chain 2 (GPIO 19..37); must equal NUM_GPIO_1
- CFG_BITS, 13, configuration bits per control block
- CLK_DIV, 2, system clocks per serial-clock half period (≥1)

Ports (one clock; reset is asynchronous and active-high):
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- xfer_start  in  1  single-cycle request to start an automatic transfer
- gpio_config  in  38*CFG_BITS  flat config words; word g at [g*CFG_BITS +: CFG_BITS]
- bb_enable  in  1  bit-bang mode select
- bb_resetn, bb_load, bb_clock  in  1 each  bit-bang control levels
- bb_data_1, bb_data_2  in  1 each  bit-bang data, chain 1 and chain 2
- serial_clock, serial_load, serial_resetn  out  1 each  chain controls, shared by both chains
- serial_data_1, serial_data_2  out  1 each  chain data
- busy  out  1  automatic transfer in progress
- done  out  1  single-cycle pulse at transfer end

## Operation
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, LOAD, FINISH.
- All outputs are registered.
- Reset values: serial_resetn=0, all other outputs 0.
  - serial_resetn goes to 1 in the first cycle after reset deasserts.
  - This holds in both IDLE and automatic mode, unless bit-bang mode overrides it.
- IDLE with bb_enable=1: each serial_* output follows its bb_* counterpart, one cycle late.
- IDLE with bb_enable=0: serial_clock, serial_load and both serial_data outputs are 0; serial_resetn=1.
- xfer_start is accepted only in IDLE with bb_enable=0. It is ignored in all other cases (busy, or bit-bang mode).
- Word order, so that data lands in the right block (first-shifted data travels furthest):
  - Chain 1 shifts GPIO 18 down to GPIO 0.
  - Chain 2 shifts GPIO 19 up to GPIO 37.
- Each word is shifted MSB first (bit 12 down to bit 0).
- Config capture: at the start of each word, the 13-bit slices for both chains are copied into two staging shift registers.
  - gpio_config must stay stable only while busy. Changes made while busy may corrupt words not yet captured.
- SHIFT_LO: serial_clock=0, data valid; lasts CLK_DIV cycles. SHIFT_HI: serial_clock=1; lasts CLK_DIV cycles.
- A bit counter runs 0..CFG_BITS-1 and a word counter runs 0..NUM_GPIO_1-1. Both wrap to 0 on the next word or next transfer.
- After the last HI phase the FSM enters LOAD.
  - LOAD: serial_load=1 and serial_clock=0 for CLK_DIV cycles.
  - FINISH: serial_load=0 for CLK_DIV cycles, then done=1 for one cycle and return to IDLE.
- bb_enable changing during a transfer has no effect until IDLE.
- Reset mid-transfer: the FSM returns to IDLE and all outputs go to reset values, including serial_resetn=0, which clears the chains. No done pulse is issued.

## Timing
- Let xfer_start be sampled high at cycle 0, and H=CLK_DIV.
- busy=1 from cycle 1 through the done cycle inclusive.
- Bit k (k=0..NUM_GPIO_1*CFG_BITS-1) is presented at cycle 1+2kH.
  - serial_clock rises at 1+2kH+H.
  - serial_clock falls at 1+2(k+1)H.
- serial_load=1 during cycles [1+2NH, 1+2NH+H), with N=NUM_GPIO_1*CFG_BITS.
- done at cycle 1+2NH+2H; busy falls the following cycle.
- Defaults (N=247, H=2): load at cycles 989–990, done at cycle 993.
- A new xfer_start is accepted as early as the cycle after busy falls.

## Structure
- Shared package gpio_cfg_pkg holds:
  - the CFG_BITS and GPIO count constants;
  - the FSM state enum;
  - the config-word field offsets (mgmt enable, output disable, and so on) used by housekeeping and the control blocks.
- Sub-module gpio_serial_divider: the half-period counter that produces phase-advance strobes. It is instantiated once.
- Everything else is a single module.

## Test plan
- Reset: assert reset mid-SHIFT -> serial_resetn=0 and busy=0 immediately; after release, serial_resetn=1 and no done pulse.
- Full transfer, H=2, word g = g+1:
  - a chain-model shift register captures GPIO0=0x001 and GPIO37=0x026 after load;
  - load pulse at cycles 989–990; done at cycle 993.
- Pattern 0x1803 on GPIO 0 and 37, all other words 0 -> chain model shows bits 12, 11, 1, 0 set on those blocks only.
- Bit-bang: bb_enable=1, toggle bb_clock 12 times with bb_data_1/2 -> outputs mirror the inputs with 1-cycle latency; xfer_start is ignored.
- Collision: xfer_start while busy, and bb_enable raised mid-transfer -> the transfer completes unchanged, then bit-bang pass-through starts in IDLE.
- CLK_DIV=1 build -> bit period is 2 cycles and done arrives at cycle 497.
